// File: rtl/wb_forward_unit.sv
// Writer side of the 32x64 register file: MEM/WB pipeline registers, regfile write
// port, decode-operand bypass network and load-use hazard detection.
module wb_forward_unit #(
    parameter int         WIDTH    = 64,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_dest,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic [WIDTH-1:0] mem_load_data,
    input  logic [4:0]       rd_reg1,
    input  logic [4:0]       rd_reg2,
    input  logic [WIDTH-1:0] rf_data1,
    input  logic [WIDTH-1:0] rf_data2,
    output logic [WIDTH-1:0] op_data1,
    output logic [WIDTH-1:0] op_data2,
    output logic             stall,
    output logic [WIDTH-1:0] WriteData,
    output logic [4:0]       WriteRegister,
    output logic             RegWrite
);

    logic             ex_we;

    logic             m_we_q, m_we_d;
    logic             m_memtoreg_q, m_memtoreg_d;
    logic [4:0]       m_dest_q, m_dest_d;
    logic [WIDTH-1:0] m_alu_q, m_alu_d;
    logic [WIDTH-1:0] m_res;

    logic             w_we_q, w_we_d;
    logic [4:0]       w_dest_q, w_dest_d;
    logic [WIDTH-1:0] w_data_q, w_data_d;

    logic [4:0]       rd_reg  [2];
    logic [WIDTH-1:0] rf_data [2];
    logic [WIDTH-1:0] op_data [2];
    logic [1:0]       load_hit;

    // Writes to the hardwired-zero register are squashed here so they never forward.
    assign ex_we = ex_valid & ex_regwrite & (ex_dest != ZERO_REG);
    assign m_res = m_memtoreg_q ? mem_load_data : m_alu_q;

    always_comb begin
        m_we_d       = ex_we;
        m_memtoreg_d = ex_memtoreg;
        m_dest_d     = ex_dest;
        m_alu_d      = ex_alu_result;
        w_we_d       = m_we_q;
        w_dest_d     = m_dest_q;
        w_data_d     = m_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_we_q       <= 1'b0;
            m_memtoreg_q <= 1'b0;
            m_dest_q     <= ZERO_REG;
            m_alu_q      <= '0;
            w_we_q       <= 1'b0;
            w_dest_q     <= ZERO_REG;
            w_data_q     <= '0;
        end else begin
            m_we_q       <= m_we_d;
            m_memtoreg_q <= m_memtoreg_d;
            m_dest_q     <= m_dest_d;
            m_alu_q      <= m_alu_d;
            w_we_q       <= w_we_d;
            w_dest_q     <= w_dest_d;
            w_data_q     <= w_data_d;
        end
    end

    assign rd_reg[0]  = rd_reg1;
    assign rd_reg[1]  = rd_reg2;
    assign rf_data[0] = rf_data1;
    assign rf_data[1] = rf_data2;

    // Youngest producer wins; a load still in EX cannot supply data yet, so it stalls.
    always_comb begin
        load_hit = 2'b00;
        for (int n = 0; n < 2; n++) begin
            op_data[n] = rf_data[n];
            if (rd_reg[n] == ZERO_REG) begin
                op_data[n] = rf_data[n];
            end else if (ex_we && (ex_dest == rd_reg[n])) begin
                if (ex_memtoreg) begin
                    load_hit[n] = 1'b1;
                end else begin
                    op_data[n] = ex_alu_result;
                end
            end else if (m_we_q && (m_dest_q == rd_reg[n])) begin
                op_data[n] = m_res;
            end else if (w_we_q && (w_dest_q == rd_reg[n])) begin
                op_data[n] = w_data_q;
            end
        end
    end

    assign op_data1      = op_data[0];
    assign op_data2      = op_data[1];
    assign stall         = |load_hit;

    assign RegWrite      = w_we_q;
    assign WriteRegister = w_dest_q;
    assign WriteData     = w_data_q;

endmodule
